lcd_write_sequencer: RTL

- Multi-cycle Nios II custom instruction that drives an HD44780-compatible character LCD through one write transaction per issue.
- Software passes a command or data byte. The block generates RS/data setup, the E pulse, hold, and the controller execution wait, then pulses done.
- Replaces software-timed pin toggling; sits between the CPU custom-instruction port and the LCD pins.

---
 rtl/lcd_write_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_write_sequencer.sv
// HD44780 write sequencer for a multi-cycle Nios II custom instruction: one command/data byte per issue.
// Optional power-on init sequence (0x38, 0x0C, 0x01, 0x06) is enabled by defining LCD_INIT_EN.
module lcd_write_sequencer #(
    parameter int T_SETUP   = 4,
    parameter int T_EN_HIGH = 25,
    parameter int T_HOLD    = 2,
    parameter int T_EXEC    = 2000,
    parameter int T_CLEAR   = 82000,
`ifdef LCD_INIT_EN
    parameter int T_POWERUP = 750000,
`endif
    parameter int CNT_W     = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data
);

    localparam logic [CNT_W-1:0] SETUP_LEN = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] EN_LEN    = CNT_W'(T_EN_HIGH);
    localparam logic [CNT_W-1:0] HOLD_LEN  = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] EXEC_LEN  = CNT_W'(T_EXEC);
    localparam logic [CNT_W-1:0] CLEAR_LEN = CNT_W'(T_CLEAR);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef LCD_INIT_EN
    localparam logic [CNT_W-1:0] PWR_LEN   = CNT_W'(T_POWERUP);
`endif

`ifdef LCD_INIT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_DONE, S_INIT_PWR, S_INIT_LOAD
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_DONE
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   texec_q, texec_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic [31:0]        result_q, result_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               cntLast;
    logic               unusedDataa;
`ifdef LCD_INIT_EN
    logic               init_q, init_d;
    logic [1:0]         idx_q, idx_d;
`endif

    assign unusedDataa = ^dataa[31:9];

    // Clear Display and Return Home need the long controller execution wait.
    function automatic logic isSlowCmd(input logic rs, input logic [7:0] b);
        return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
    endfunction

`ifdef LCD_INIT_EN
    function automatic logic [7:0] initCmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    assign cntLast = (cnt_q <= CNT_ONE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        texec_d  = texec_q;
        rs_d     = rs_q;
        data_d   = data_q;
        result_d = result_q;
`ifdef LCD_INIT_EN
        init_d   = init_q;
        idx_d    = idx_q;
`endif
        if (!cntLast) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rs_d    = dataa[8];
                    data_d  = dataa[7:0];
                    texec_d = isSlowCmd(dataa[8], dataa[7:0]) ? CLEAR_LEN : EXEC_LEN;
                    cnt_d   = SETUP_LEN;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cntLast) begin
                    cnt_d   = EN_LEN;
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cntLast) begin
                    cnt_d   = HOLD_LEN;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cntLast) begin
                    cnt_d   = texec_q;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cntLast) begin
`ifdef LCD_INIT_EN
                    if (init_q) begin
                        if (idx_q == 2'd3) begin
                            init_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = S_INIT_LOAD;
                        end
                    end else begin
                        result_d = {23'b0, rs_q, data_q};
                        state_d  = S_DONE;
                    end
`else
                    result_d = {23'b0, rs_q, data_q};
                    state_d  = S_DONE;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef LCD_INIT_EN
            // The counter is zero straight out of reset, so the power-up wait is loaded first.
            S_INIT_PWR: begin
                if (cnt_q == '0) begin
                    cnt_d = PWR_LEN;
                end else if (cntLast) begin
                    state_d = S_INIT_LOAD;
                end
            end
            S_INIT_LOAD: begin
                rs_d    = 1'b0;
                data_d  = initCmd(idx_q);
                texec_d = isSlowCmd(1'b0, initCmd(idx_q)) ? CLEAR_LEN : EXEC_LEN;
                cnt_d   = SETUP_LEN;
                state_d = S_SETUP;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
        en_d   = (state_d == S_PULSE);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
`ifdef LCD_INIT_EN
            state_q  <= S_INIT_PWR;
            init_q   <= 1'b1;
            idx_q    <= 2'd0;
`else
            state_q  <= S_IDLE;
`endif
            cnt_q    <= '0;
            texec_q  <= '0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            result_q <= 32'h0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (clk_en) begin
`ifdef LCD_INIT_EN
            init_q   <= init_d;
            idx_q    <= idx_d;
`endif
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            texec_q  <= texec_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            result_q <= result_d;
            en_q     <= en_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign lcd_en   = en_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_data = data_q;

endmodule
